// File: rtl/oc8051_int_ctrl.sv
// 8051 interrupt controller: latches the five sources, applies IE/IP and
// issues a one-cycle request (int_req; "int" is a reserved word) with the vector low byte.
module oc8051_int_ctrl #(
   parameter logic [7:0] VEC_BASE = 8'h03
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       int0_n,
   input  logic       int1_n,
   input  logic       it0,
   input  logic       it1,
   input  logic       tf0_set,
   input  logic       tf1_set,
   input  logic       ri,
   input  logic       ti,
   input  logic [7:0] ie,
   input  logic [7:0] ip,
   input  logic [3:0] sw_clr,
   input  logic       ack,
   input  logic       reti,
   output logic       int_req,
   output logic [7:0] int_v,
   output logic [3:0] tcon_flags,
   output logic [1:0] isr_lvl
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   logic       int0_s1_r, int0_sync_r, int0_prev_r;
   logic       int1_s1_r, int1_sync_r, int1_prev_r;
   logic       ie0_r, ie1_r, tf0_r, tf1_r;
   logic       fall0_s, fall1_s;
   logic       ie0_s, ie1_s, tf0_s, tf1_s;
   logic [3:0] clr_s, ack_clr_s;
   logic [4:0] req_s, hi_req_s, lo_req_s;
   logic       sel_valid_s, sel_lvl_s;
   logic [2:0] sel_src_s;
   state_t     state_r, state_nxt_s;
   logic       int_r, int_nxt_s;
   logic [7:0] int_v_r, int_v_nxt_s;
   logic [2:0] src_r, src_nxt_s;
   logic       lvl_r, lvl_nxt_s;
   logic       ack_take_s;
   logic [1:0] isr_lvl_r, isr_nxt_s;
   logic       unused_s;

   // Lowest set index wins: ie0 > tf0 > ie1 > tf1 > serial.
   function automatic logic [2:0] first_set(input logic [4:0] v);
      if (v[0]) begin
         return 3'd0;
      end else if (v[1]) begin
         return 3'd1;
      end else if (v[2]) begin
         return 3'd2;
      end else if (v[3]) begin
         return 3'd3;
      end else begin
         return 3'd4;
      end
   endfunction

   assign unused_s = ^{ie[6:5], ip[7:5]};

   // Two-flop pin synchronizers plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         int0_s1_r   <= 1'b1;
         int0_sync_r <= 1'b1;
         int0_prev_r <= 1'b1;
         int1_s1_r   <= 1'b1;
         int1_sync_r <= 1'b1;
         int1_prev_r <= 1'b1;
      end else begin
         int0_s1_r   <= int0_n;
         int0_sync_r <= int0_s1_r;
         int0_prev_r <= int0_sync_r;
         int1_s1_r   <= int1_n;
         int1_sync_r <= int1_s1_r;
         int1_prev_r <= int1_sync_r;
      end
   end

   assign fall0_s = int0_prev_r & ~int0_sync_r;
   assign fall1_s = int1_prev_r & ~int1_sync_r;

   // A set in flight is already visible so the request leaves one cycle later.
   assign ie0_s = it0 ? (ie0_r | fall0_s) : ~int0_sync_r;
   assign ie1_s = it1 ? (ie1_r | fall1_s) : ~int1_sync_r;
   assign tf0_s = tf0_r | tf0_set;
   assign tf1_s = tf1_r | tf1_set;
   assign clr_s = sw_clr | ack_clr_s;

   // Flag storage; set has priority over any clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ie0_r <= 1'b0;
         ie1_r <= 1'b0;
         tf0_r <= 1'b0;
         tf1_r <= 1'b0;
      end else begin
         ie0_r <= it0 ? (fall0_s | (ie0_r & ~clr_s[0])) : 1'b0;
         ie1_r <= it1 ? (fall1_s | (ie1_r & ~clr_s[2])) : 1'b0;
         tf0_r <= tf0_set | (tf0_r & ~clr_s[1]);
         tf1_r <= tf1_set | (tf1_r & ~clr_s[3]);
      end
   end

   assign req_s    = {ri | ti, tf1_s, ie1_s, tf0_s, ie0_s} & ie[4:0] & {5{ie[7]}};
   assign hi_req_s = req_s & ip[4:0];
   assign lo_req_s = req_s & ~ip[4:0];

   // Pick the winning eligible source, high level first.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_lvl_s   = 1'b0;
      sel_src_s   = 3'd0;
      if (!isr_lvl_r[1] && (|hi_req_s)) begin
         sel_valid_s = 1'b1;
         sel_lvl_s   = 1'b1;
         sel_src_s   = first_set(hi_req_s);
      end else if ((isr_lvl_r == 2'b00) && (|lo_req_s)) begin
         sel_valid_s = 1'b1;
         sel_lvl_s   = 1'b0;
         sel_src_s   = first_set(lo_req_s);
      end else begin
         sel_valid_s = 1'b0;
      end
   end

   // Request FSM next state and registered-output next values.
   always_comb begin
      state_nxt_s = state_r;
      int_nxt_s   = 1'b0;
      int_v_nxt_s = int_v_r;
      src_nxt_s   = src_r;
      lvl_nxt_s   = lvl_r;
      ack_take_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (sel_valid_s) begin
               int_nxt_s   = 1'b1;
               int_v_nxt_s = VEC_BASE + {2'b00, sel_src_s, 3'b000};
               src_nxt_s   = sel_src_s;
               lvl_nxt_s   = sel_lvl_s;
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         REQ: begin
            state_nxt_s = WAIT;
         end
         WAIT: begin
            if (ack) begin
               ack_take_s  = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Ack clears only flags that latch: edge-mode pins and timer overflows.
   always_comb begin
      ack_clr_s = 4'b0000;
      if (ack_take_s) begin
         case (src_r)
            3'd0:    ack_clr_s[0] = it0;
            3'd1:    ack_clr_s[1] = 1'b1;
            3'd2:    ack_clr_s[2] = it1;
            3'd3:    ack_clr_s[3] = 1'b1;
            default: ack_clr_s    = 4'b0000;
         endcase
      end else begin
         ack_clr_s = 4'b0000;
      end
   end

   // In-service stack: RETI pops the highest level before an ack pushes.
   always_comb begin
      isr_nxt_s = isr_lvl_r;
      if (reti) begin
         if (isr_nxt_s[1]) begin
            isr_nxt_s[1] = 1'b0;
         end else begin
            isr_nxt_s[0] = 1'b0;
         end
      end else begin
         isr_nxt_s = isr_lvl_r;
      end
      if (ack_take_s) begin
         isr_nxt_s[lvl_r] = 1'b1;
      end else begin
         isr_nxt_s = isr_nxt_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         int_r     <= 1'b0;
         int_v_r   <= 8'h00;
         src_r     <= 3'd0;
         lvl_r     <= 1'b0;
         isr_lvl_r <= 2'b00;
      end else begin
         state_r   <= state_nxt_s;
         int_r     <= int_nxt_s;
         int_v_r   <= int_v_nxt_s;
         src_r     <= src_nxt_s;
         lvl_r     <= lvl_nxt_s;
         isr_lvl_r <= isr_nxt_s;
      end
   end

   assign int_req    = int_r;
   assign int_v      = int_v_r;
   assign tcon_flags = {tf1_s, ie1_s, tf0_s, ie0_s};
   assign isr_lvl    = isr_lvl_r;

endmodule

// File: tb/tb_oc8051_int_ctrl.sv
// Directed bench for oc8051_int_ctrl; each task drives one scenario and
// compares against hand-computed values.
module tb_oc8051_int_ctrl;

   logic       clk = 1'b0;
   logic       rst, int0_n, int1_n, it0, it1, tf0_set, tf1_set, ri, ti;
   logic [7:0] ie, ip;
   logic [3:0] sw_clr;
   logic       ack, reti;
   logic       int_req;
   logic [7:0] int_v;
   logic [3:0] tcon_flags;
   logic [1:0] isr_lvl;
   int         checks = 0;
   int         errors = 0;

   oc8051_int_ctrl #(.VEC_BASE(8'h03)) dut (
      .clk(clk), .rst(rst), .int0_n(int0_n), .int1_n(int1_n), .it0(it0), .it1(it1),
      .tf0_set(tf0_set), .tf1_set(tf1_set), .ri(ri), .ti(ti), .ie(ie), .ip(ip),
      .sw_clr(sw_clr), .ack(ack), .reti(reti), .int_req(int_req), .int_v(int_v),
      .tcon_flags(tcon_flags), .isr_lvl(isr_lvl)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of cycles until int_req, or -1 on timeout.
   task automatic wait_int(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!int_req && n < 20);
      if (!int_req) n = -1;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic pulse_reti();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; int0_n = 1'b1; int1_n = 1'b1; it0 = 1'b0; it1 = 1'b0;
      tf0_set = 1'b0; tf1_set = 1'b0; ri = 1'b0; ti = 1'b0;
      ie = 8'h00; ip = 8'h00; sw_clr = 4'b0000; ack = 1'b0; reti = 1'b0;
      repeat (3) tick();
      checks++;
      if ({int_req, int_v, tcon_flags, isr_lvl} !== 15'h0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 0", {int_req, int_v, tcon_flags, isr_lvl});
      end
      rst = 1'b0;
      tick();
      pulse_reti();
      checks++;
      if (isr_lvl !== 2'b00) begin
         errors++;
         $display("FAIL reti_when_idle: got %b expected 00", isr_lvl);
      end
   endtask

   task automatic test_edge_int0();
      int n;
      ie = 8'h81; it0 = 1'b1;
      int0_n = 1'b0;
      wait_int(n);
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL edge_latency: got %0d expected 3", n);
      end
      checks++;
      if (int_v !== 8'h03 || tcon_flags[0] !== 1'b1) begin
         errors++;
         $display("FAIL edge_vector: got %h/%b expected 03/1", int_v, tcon_flags[0]);
      end
      tick();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL int_one_cycle: got %b expected 0", int_req);
      end
      pulse_ack();
      checks++;
      if (isr_lvl !== 2'b01 || tcon_flags !== 4'b0000) begin
         errors++;
         $display("FAIL edge_ack: got isr %b tcon %b expected 01 0000", isr_lvl, tcon_flags);
      end
      int0_n = 1'b1;
      pulse_reti();
      checks++;
      if (isr_lvl !== 2'b00) begin
         errors++;
         $display("FAIL edge_reti: got %b expected 00", isr_lvl);
      end
      ie = 8'h00; it0 = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_timers();
      int n;
      ie = 8'h8A; ip = 8'h00;
      tf0_set = 1'b1; tf1_set = 1'b1;
      tick();
      tf0_set = 1'b0; tf1_set = 1'b0;
      checks++;
      if (int_req !== 1'b1 || int_v !== 8'h0B || tcon_flags !== 4'b1010) begin
         errors++;
         $display("FAIL timer_first: got %b %h %b expected 1 0b 1010", int_req, int_v, tcon_flags);
      end
      tick();
      pulse_ack();
      checks++;
      if (tcon_flags !== 4'b1000 || isr_lvl !== 2'b01) begin
         errors++;
         $display("FAIL timer_ack: got %b %b expected 1000 01", tcon_flags, isr_lvl);
      end
      tick();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL timer_blocked: got %b expected 0", int_req);
      end
      pulse_reti();
      wait_int(n);
      checks++;
      if (n !== 1 || int_v !== 8'h1B) begin
         errors++;
         $display("FAIL timer_second: got %0d %h expected 1 1b", n, int_v);
      end
      tick();
      pulse_ack();
      checks++;
      if (tcon_flags !== 4'b0000) begin
         errors++;
         $display("FAIL timer_cleared: got %b expected 0000", tcon_flags);
      end
      pulse_reti();
      ie = 8'h00;
   endtask

   task automatic test_nested();
      int n;
      int bad;
      ie = 8'h82; ip = 8'h00;
      tf0_set = 1'b1;
      tick();
      tf0_set = 1'b0;
      tick();
      pulse_ack();
      ie = 8'h90; ip = 8'h10; ti = 1'b1;
      wait_int(n);
      checks++;
      if (n !== 1 || int_v !== 8'h23) begin
         errors++;
         $display("FAIL nest_high: got %0d %h expected 1 23", n, int_v);
      end
      ti = 1'b0;
      tick();
      pulse_ack();
      checks++;
      if (isr_lvl !== 2'b11 || int_v !== 8'h23) begin
         errors++;
         $display("FAIL nest_push: got %b %h expected 11 23", isr_lvl, int_v);
      end
      ie = 8'h82;
      tf0_set = 1'b1;
      tick();
      tf0_set = 1'b0;
      bad = 0;
      repeat (3) begin
         tick();
         if (int_req) bad++;
      end
      pulse_reti();
      checks++;
      if (isr_lvl !== 2'b01) begin
         errors++;
         $display("FAIL nest_pop1: got %b expected 01", isr_lvl);
      end
      repeat (3) begin
         tick();
         if (int_req) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL nest_low_blocked: got %0d requests expected 0", bad);
      end
      pulse_reti();
      wait_int(n);
      checks++;
      if (n !== 1 || int_v !== 8'h0B) begin
         errors++;
         $display("FAIL nest_low_after: got %0d %h expected 1 0b", n, int_v);
      end
      tick();
      pulse_ack();
      pulse_reti();
      ie = 8'h00; ip = 8'h00;
   endtask

   task automatic test_level_int1();
      int n;
      it1 = 1'b0; ie = 8'h84;
      int1_n = 1'b0;
      wait_int(n);
      checks++;
      if (n !== 3 || int_v !== 8'h13) begin
         errors++;
         $display("FAIL level_vector: got %0d %h expected 3 13", n, int_v);
      end
      tick();
      pulse_ack();
      checks++;
      if (tcon_flags[2] !== 1'b1 || isr_lvl !== 2'b01) begin
         errors++;
         $display("FAIL level_held: got %b %b expected 1 01", tcon_flags[2], isr_lvl);
      end
      int1_n = 1'b1;
      repeat (2) tick();
      checks++;
      if (tcon_flags[2] !== 1'b0) begin
         errors++;
         $display("FAIL level_release: got %b expected 0", tcon_flags[2]);
      end
      pulse_reti();
      ie = 8'h00;
   endtask

   task automatic test_sw_clr();
      tf0_set = 1'b1;
      tick();
      tf0_set = 1'b0;
      sw_clr = 4'b0010;
      tick();
      sw_clr = 4'b0000;
      checks++;
      if (tcon_flags !== 4'b0000) begin
         errors++;
         $display("FAIL sw_clear: got %b expected 0000", tcon_flags);
      end
      tf1_set = 1'b1; sw_clr = 4'b1000;
      tick();
      tf1_set = 1'b0; sw_clr = 4'b0000;
      checks++;
      if (tcon_flags !== 4'b1000) begin
         errors++;
         $display("FAIL set_beats_clear: got %b expected 1000", tcon_flags);
      end
      sw_clr = 4'b1000;
      tick();
      sw_clr = 4'b0000;
   endtask

   task automatic test_ea_and_reset_in_wait();
      int n;
      int bad;
      ie = 8'h1F; ip = 8'h00; it0 = 1'b0; it1 = 1'b0;
      int0_n = 1'b0; int1_n = 1'b0; ri = 1'b1;
      tf0_set = 1'b1; tf1_set = 1'b1;
      tick();
      tf0_set = 1'b0; tf1_set = 1'b0;
      bad = int_req ? 1 : 0;
      repeat (4) begin
         tick();
         if (int_req) bad++;
      end
      checks++;
      if (bad !== 0 || tcon_flags !== 4'b1111) begin
         errors++;
         $display("FAIL ea_gate: got %0d %b expected 0 1111", bad, tcon_flags);
      end
      ie = 8'h9F;
      wait_int(n);
      checks++;
      if (n !== 1 || int_v !== 8'h03) begin
         errors++;
         $display("FAIL ea_enable: got %0d %h expected 1 03", n, int_v);
      end
      tick();
      pulse_ack();
      checks++;
      if (isr_lvl !== 2'b01 || tcon_flags !== 4'b1111) begin
         errors++;
         $display("FAIL level_not_cleared: got %b %b expected 01 1111", isr_lvl, tcon_flags);
      end
      ip = 8'h02;
      wait_int(n);
      checks++;
      if (n !== 1 || int_v !== 8'h0B) begin
         errors++;
         $display("FAIL high_preempt: got %0d %h expected 1 0b", n, int_v);
      end
      tick();
      rst = 1'b1; int0_n = 1'b1; int1_n = 1'b1; ri = 1'b0; ie = 8'h00; ip = 8'h00;
      tick();
      checks++;
      if (int_req !== 1'b0 || isr_lvl !== 2'b00 || tcon_flags !== 4'b0000) begin
         errors++;
         $display("FAIL reset_in_wait: got %b %b %b expected 0 00 0000", int_req, isr_lvl, tcon_flags);
      end
      tick();
      rst = 1'b0;
      pulse_ack();
      bad = 0;
      repeat (3) begin
         tick();
         if (int_req || isr_lvl !== 2'b00) bad++;
      end
      checks++;
      if (bad !== 0 || isr_lvl !== 2'b00) begin
         errors++;
         $display("FAIL ack_after_reset: got %0d %b expected 0 00", bad, isr_lvl);
      end
   endtask

   initial begin
      test_reset();
      test_edge_int0();
      test_timers();
      test_nested();
      test_level_int1();
      test_sw_clr();
      test_ea_and_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
